// File: rtl/display_scan.sv
// Scan driver for a 4-digit common-anode 7-segment display.
// Cycles through the snapshot nibbles with an all-anodes-off guard interval and optional leading-zero blanking.
module display_scan #(
    parameter int SHOW_CYCLES  = 6750,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        load_i,
    input  logic        blank_lz_en,
    output logic [3:0]  s_muxfue,
    output logic [3:0]  an_o,
    output logic        frame_o
);

    localparam int MAX_LEN = (SHOW_CYCLES > GUARD_CYCLES) ? SHOW_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic {S_GUARD, S_SHOW} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       idx, idx_nx;
    logic [15:0]      snap, snap_nx;
    logic [3:0]       mux_nx;
    logic [3:0]       an_nx;
    logic             frame_nx;
    logic             last;

    // Digit k (k >= 1) is a leading zero when nibbles k..3 are all zero.
    function automatic logic digit_blanked(input logic [15:0] v, input logic [1:0] k,
                                           input logic en);
        logic b;
        b = en && (k != 2'd0);
        for (int j = 1; j < 4; j++) begin
            if (j >= int'(k) && v[4*j +: 4] != 4'h0) b = 1'b0;
        end
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_GUARD;
            cnt      <= '0;
            idx      <= 2'd3;
            snap     <= 16'h0000;
            s_muxfue <= 4'h0;
            an_o     <= 4'b1111;
            frame_o  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            snap     <= snap_nx;
            s_muxfue <= mux_nx;
            an_o     <= an_nx;
            frame_o  <= frame_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        snap_nx  = load_i ? data_i : snap;
        mux_nx   = s_muxfue;
        an_nx    = an_o;
        frame_nx = 1'b0;
        last     = (state == S_SHOW) ? (cnt == SHOW_LAST) : (cnt == GUARD_LAST);

        if (last) begin
            cnt_nx = '0;
            if (state == S_GUARD) begin
                // The digit being entered is decoded from the pre-load snapshot.
                state_nx = S_SHOW;
                idx_nx   = idx + 2'd1;
                mux_nx   = snap[{idx_nx, 2'b00} +: 4];
                an_nx    = digit_blanked(snap, idx_nx, blank_lz_en) ? 4'b1111
                                                                    : ~(4'b0001 << idx_nx);
                frame_nx = (idx_nx == 2'd0);
            end else begin
                state_nx = S_GUARD;
                an_nx    = 4'b1111;
            end
        end
    end

endmodule
